calc_requester: RTL and testbench

Host-side initiator for the calculator core's operand/operation port. Accepts one calculation request from the UI/keypad logic over a valid/ready handshake, drives operands and operation code into the core, pulses the core's `start`, waits for the core to drop and re-raise `ready`, then returns the 32-bit result with status. Sits between the front-panel controller and the calculator core, on the same clock.

---
 rtl/calc_requester.sv | 170 +++++++++++++++++
 tb/tb_calc_requester.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_requester.sv
// calc_requester: host-side initiator for the calculator core.
// Accepts one request over valid/ready, launches it on the core with a
// multi-cycle start strobe, tracks the core's ready handshake with timeouts,
// and returns the captured result with error/timeout status.
module calc_requester #(
  parameter int unsigned START_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter int unsigned DONE_TIMEOUT = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [2:0]  req_op,
  output logic        req_ready,
  output logic [31:0] core_datoA,
  output logic [31:0] core_datoB,
  output logic [2:0]  core_op,
  output logic        core_start,
  input  logic [31:0] core_resultado,
  input  logic        core_ready,
  input  logic        core_error,
  output logic        rsp_valid,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int unsigned MAX_AD  = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int unsigned CNT_MAX = (START_CYCLES > MAX_AD) ? START_CYCLES : MAX_AD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  // Ready held high this long after launch means the core finished without an ack
  // (unknown ops, div/mod by zero, or a core that never drops ready).
  localparam int unsigned NOACK_CYCLES = 8;
  localparam int unsigned HI_W         = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RESPOND
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [HI_W-1:0]   hi_cnt;
  logic              ack_seen;
  logic              core_ready_q;
  logic              core_error_q;
  logic [31:0]       core_result_q;

  // Register all core outputs; the FSM only looks at sampled values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready_q  <= 1'b0;
      core_error_q  <= 1'b0;
      core_result_q <= 32'd0;
    end else begin
      core_ready_q  <= core_ready;
      core_error_q  <= core_error;
      core_result_q <= core_resultado;
    end
  end

  // Request sequencer: launch, ack/done tracking with timeouts, response strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      hi_cnt      <= '0;
      ack_seen    <= 1'b0;
      req_ready   <= 1'b1;
      core_datoA  <= 32'd0;
      core_datoB  <= 32'd0;
      core_op     <= 3'd0;
      core_start  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            core_datoA <= req_a;
            core_datoB <= req_b;
            core_op    <= req_op;
            core_start <= 1'b1;
            cnt        <= CNT_W'(START_CYCLES - 1);
            ack_seen   <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          // A fast core may already drop ready while start is still high.
          if (!core_ready_q) ack_seen <= 1'b1;
          if (cnt == '0) begin
            core_start <= 1'b0;
            hi_cnt     <= '0;
            state      <= S_WAIT_ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_WAIT_ACK: begin
          if (ack_seen || !core_ready_q) begin
            cnt   <= '0;
            state <= S_WAIT_DONE;
          end else if (hi_cnt == HI_W'(NOACK_CYCLES - 1)) begin
            rsp_result  <= core_result_q;
            rsp_error   <= core_error_q;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RESPOND;
          end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            rsp_result  <= 32'd0;
            rsp_error   <= core_error_q;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= S_RESPOND;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            hi_cnt <= hi_cnt + HI_W'(1);
          end
        end

        S_WAIT_DONE: begin
          if (core_ready_q) begin
            rsp_result  <= core_result_q;
            rsp_error   <= core_error_q;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RESPOND;
          end else if (cnt == CNT_W'(DONE_TIMEOUT - 1)) begin
            rsp_result  <= 32'd0;
            rsp_error   <= core_error_q;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= S_RESPOND;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_RESPOND: begin
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          core_start <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_requester.sv
// Directed bench for calc_requester with a behavioural core model and a
// scoreboard of expected responses.
module tb_calc_requester;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        req_ready;
  logic [31:0] core_datoA;
  logic [31:0] core_datoB;
  logic [2:0]  core_op;
  logic        core_start;
  logic [31:0] core_resultado;
  logic        core_ready;
  logic        core_error;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        busy;

  calc_requester dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_op         (req_op),
    .req_ready      (req_ready),
    .core_datoA     (core_datoA),
    .core_datoB     (core_datoB),
    .core_op        (core_op),
    .core_start     (core_start),
    .core_resultado (core_resultado),
    .core_ready     (core_ready),
    .core_error     (core_error),
    .rsp_valid      (rsp_valid),
    .rsp_result     (rsp_result),
    .rsp_error      (rsp_error),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Core model knobs: 0 normal, 1 never drops ready, 2 drops ready and hangs.
  int          m_mode    = 0;
  int          m_busy    = 20;
  logic [31:0] m_result  = 32'd0;
  logic        m_err     = 1'b0;
  logic        m_restore = 1'b0;

  // Behavioural calculator core.
  initial begin
    core_ready     = 1'b1;
    core_error     = 1'b0;
    core_resultado = 32'd0;
    forever begin
      @(posedge core_start);
      #1;
      if (m_mode == 1) begin
        core_resultado = m_result;
        core_error     = m_err;
      end else begin
        repeat (2) @(posedge clk);
        #1 core_ready = 1'b0;
        if (m_mode == 2) begin
          core_resultado = m_result;
          core_error     = m_err;
          wait (m_restore);
          core_ready = 1'b1;
        end else begin
          repeat (m_busy) @(posedge clk);
          #1;
          core_resultado = m_result;
          core_error     = m_err;
          core_ready     = 1'b1;
        end
      end
    end
  end

  // Passive monitor sampled mid-cycle.
  int          cyc = 0;
  int          n_launch = 0;
  int          n_rsp = 0;
  int          start_run = 0;
  int          last_start_run = 0;
  int          start_rise_cyc = 0;
  int          rise_cyc = 0;
  int          rsp_cyc = 0;
  int          stab_viol = 0;
  logic        start_prev = 1'b0;
  logic        ready_prev = 1'b1;
  logic        busy_prev = 1'b0;
  logic [31:0] lat_a = 32'd0;
  logic [31:0] lat_b = 32'd0;
  logic [2:0]  lat_op = 3'd0;

  always @(posedge clk) begin
    #3;
    cyc = cyc + 1;
    if (core_start && !start_prev) begin
      n_launch       = n_launch + 1;
      start_rise_cyc = cyc;
    end
    if (core_start) start_run = start_run + 1;
    else begin
      if (start_run != 0) last_start_run = start_run;
      start_run = 0;
    end
    if (core_ready && !ready_prev) rise_cyc = cyc;
    if (rsp_valid) begin
      n_rsp   = n_rsp + 1;
      rsp_cyc = cyc;
    end
    if (busy && !busy_prev) begin
      lat_a  = core_datoA;
      lat_b  = core_datoB;
      lat_op = core_op;
    end else if (busy && (core_datoA !== lat_a || core_datoB !== lat_b || core_op !== lat_op)) begin
      stab_viol = stab_viol + 1;
    end
    start_prev = core_start;
    ready_prev = core_ready;
    busy_prev  = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_op    = op;
  endtask

  // Called at a negedge with a request driven; returns at the negedge after the accept edge.
  task automatic wait_accept(input string tag);
    bit acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = req_ready;
      @(negedge clk);
    end
    chk({tag, "_accept"}, 32'(acc), 32'd1);
  endtask

  // Waits for rsp_valid, checks busy stays high meanwhile, optionally pulses
  // req_valid (which must be ignored), then compares against the scoreboard.
  task automatic wait_rsp(input string tag, input int budget, input bit pulse);
    bit   got = 1'b0;
    bit   gap = 1'b0;
    exp_t e;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (!busy) gap = 1'b1;
      if (pulse) begin
        req_valid = ((i % 40) == 20);
        req_a     = 32'hBAD0 + 32'(i);
        req_b     = 32'd3;
        req_op    = 3'd0;
      end
    end
    if (pulse) req_valid = 1'b0;
    chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_held"}, 32'(gap), 32'd0);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        chk({tag, "_result"}, rsp_result, e.res);
        chk({tag, "_error"}, 32'(rsp_error), 32'(e.err));
        chk({tag, "_timeout"}, 32'(rsp_timeout), 32'(e.to));
      end
    end
  endtask

  int rsp_base;
  int launch_base;

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    req_op    = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_datoA", core_datoA, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Add 7+5 with a 20-cycle core.
    m_mode = 0; m_busy = 20; m_result = 32'd12; m_err = 1'b0;
    sb.push_back('{32'd12, 1'b0, 1'b0});
    drive_req(32'd7, 32'd5, 3'd0);
    wait_accept("add");
    req_valid = 1'b0;
    chk("add_start_rise", 32'(core_start), 32'd1);
    chk("add_busy", 32'(busy), 32'd1);
    chk("add_req_ready_low", 32'(req_ready), 32'd0);
    chk("add_datoA", core_datoA, 32'd7);
    chk("add_datoB", core_datoB, 32'd5);
    wait_rsp("add", 100, 1'b0);
    chk("add_ready_to_rsp", 32'(rsp_cyc - rise_cyc), 32'd2);
    @(negedge clk);
    chk("add_rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("add_result_hold", rsp_result, 32'd12);
    repeat (10) @(negedge clk);
    chk("add_rsp_count", 32'(n_rsp), 32'd1);
    chk("add_start_len", 32'(last_start_run), 32'd4);

    // Div 100/7 taking 357 cycles, with ignored request pulses.
    m_mode = 0; m_busy = 357; m_result = 32'd14; m_err = 1'b0;
    launch_base = n_launch;
    sb.push_back('{32'd14, 1'b0, 1'b0});
    drive_req(32'd100, 32'd7, 3'd3);
    wait_accept("div");
    req_valid = 1'b0;
    wait_rsp("div", 600, 1'b1);
    repeat (3) @(negedge clk);
    chk("div_single_launch", 32'(n_launch - launch_base), 32'd1);
    chk("div_operands_stable", 32'(stab_viol), 32'd0);

    // Divide by zero: ready never drops, error set.
    m_mode = 1; m_result = 32'd0; m_err = 1'b1;
    sb.push_back('{32'd0, 1'b1, 1'b0});
    drive_req(32'd9, 32'd0, 3'd3);
    wait_accept("dbz");
    req_valid = 1'b0;
    wait_rsp("dbz", 60, 1'b0);
    chk("dbz_latency", 32'(rsp_cyc - start_rise_cyc), 32'd12);
    @(negedge clk);

    // Hung core: ready drops and never returns.
    m_mode = 2; m_result = 32'hDEADBEEF; m_err = 1'b0; m_restore = 1'b0;
    sb.push_back('{32'd0, 1'b0, 1'b1});
    drive_req(32'd1, 32'd1, 3'd0);
    wait_accept("hang");
    req_valid = 1'b0;
    wait_rsp("hang", 700, 1'b0);
    m_restore = 1'b1;
    repeat (3) @(negedge clk);
    m_restore = 1'b0;

    // Add where the core never drops ready.
    m_mode = 1; m_result = 32'h1234; m_err = 1'b0;
    sb.push_back('{32'h1234, 1'b0, 1'b0});
    drive_req(32'd2, 32'd3, 3'd0);
    wait_accept("noack");
    req_valid = 1'b0;
    wait_rsp("noack", 60, 1'b0);
    @(negedge clk);

    // Reset during WAIT_DONE.
    m_mode = 0; m_busy = 60; m_result = 32'd3; m_err = 1'b0;
    drive_req(32'd1, 32'd2, 3'd0);
    wait_accept("rst_mid");
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    rsp_base = n_rsp;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_core_start", 32'(core_start), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_datoA", core_datoA, 32'd0);
    chk("rst_mid_op", 32'(core_op), 32'd0);
    chk("rst_mid_rsp_result", rsp_result, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (70) @(negedge clk);
    chk("rst_mid_no_rsp", 32'(n_rsp - rsp_base), 32'd0);
    m_busy = 10; m_result = 32'd7;
    sb.push_back('{32'd7, 1'b0, 1'b0});
    drive_req(32'd3, 32'd4, 3'd0);
    wait_accept("post_rst");
    req_valid = 1'b0;
    wait_rsp("post_rst", 100, 1'b0);
    @(negedge clk);

    // Back-to-back: mul 6*7 then sub 10-3.
    m_mode = 0; m_busy = 5; m_result = 32'd42; m_err = 1'b0;
    sb.push_back('{32'd42, 1'b0, 1'b0});
    sb.push_back('{32'd7, 1'b0, 1'b0});
    drive_req(32'd6, 32'd7, 3'd2);
    wait_accept("b2b1");
    drive_req(32'd10, 32'd3, 3'd1);
    chk("b2b1_datoA", core_datoA, 32'd6);
    wait_rsp("b2b1", 60, 1'b0);
    m_result = 32'd7;
    @(negedge clk);
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b2_busy", 32'(busy), 32'd1);
    chk("b2b2_datoA", core_datoA, 32'd10);
    chk("b2b2_datoB", core_datoB, 32'd3);
    chk("b2b2_op", 32'(core_op), 32'd1);
    wait_rsp("b2b2", 60, 1'b0);
    repeat (5) @(negedge clk);
    chk("b2b_operands_stable", 32'(stab_viol), 32'd0);
    chk("total_launches", 32'(n_launch), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
